// File: rtl/display_nibble_scanner_pkg.sv
// Shared types and default timing for the hex-digit display scanner.
package display_nibble_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW      = 2'd1,
    ST_GAP       = 2'd2,
    ST_FRAME_GAP = 2'd3
  } state_e;

  localparam int DEF_NUM_NIBBLES      = 8;
  localparam int DEF_DWELL_CYCLES     = 5_000_000;
  localparam int DEF_GAP_CYCLES       = 1_000_000;
  localparam int DEF_FRAME_GAP_CYCLES = 4_000_000;
  localparam int DEF_SUPPRESS_LZ      = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/display_nibble_scanner_if.sv
// Word-in / digit-out bundle between the CPU-side driver and the display scanner.
interface display_nibble_scanner_if
  import display_nibble_scanner_pkg::*;
#(
  parameter int NUM_NIBBLES = DEF_NUM_NIBBLES
);

  logic                     enable;
  logic [4*NUM_NIBBLES-1:0] word_in;
  logic [3:0]               nibble_out;
  logic                     blank;
  logic                     dp;
  logic [2:0]               digit_idx;
  logic                     frame_done;

  modport master (
    output enable, word_in,
    input  nibble_out, blank, dp, digit_idx, frame_done
  );

  modport slave (
    input  enable, word_in,
    output nibble_out, blank, dp, digit_idx, frame_done
  );

endinterface

// File: rtl/nibble_lz_encoder.sv
// Index of the most significant nonzero nibble of a word; 0 when the word is zero.
module nibble_lz_encoder #(
  parameter int NUM_NIBBLES = 8
) (
  input  logic [4*NUM_NIBBLES-1:0] word_i,
  output logic [2:0]               idx_o
);

  // Ascending scan: the last nonzero nibble seen is the most significant one.
  always_comb begin
    idx_o = 3'd0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (word_i[4*i +: 4] != 4'h0) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/display_nibble_scanner.sv
// Scans a word one hex digit at a time (MS first) with dwell, inter-digit gap and frame gap.
module display_nibble_scanner
  import display_nibble_scanner_pkg::*;
#(
  parameter int NUM_NIBBLES      = DEF_NUM_NIBBLES,
  parameter int DWELL_CYCLES     = DEF_DWELL_CYCLES,
  parameter int GAP_CYCLES       = DEF_GAP_CYCLES,
  parameter int FRAME_GAP_CYCLES = DEF_FRAME_GAP_CYCLES,
  parameter int SUPPRESS_LZ      = DEF_SUPPRESS_LZ
) (
  input  logic                     clk,
  input  logic                     reset,
  display_nibble_scanner_if.slave  bus
);

  localparam int TIMER_MAX = max3(DWELL_CYCLES, GAP_CYCLES, FRAME_GAP_CYCLES);
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] FGAP_LAST  = TW'(FRAME_GAP_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [4*NUM_NIBBLES-1:0] snap_q, snap_d;
  logic [2:0]               idx_q, idx_d;

  logic [3:0] nibble_out_q, nibble_out_d;
  logic       blank_q, blank_d;
  logic       dp_q, dp_d;
  logic [2:0] digit_idx_q, digit_idx_d;
  logic       frame_done_q, frame_done_d;

  logic [2:0] lz_idx;
  logic [2:0] start_idx;
  logic [3:0] nib_sel;
  logic       show_d;

  nibble_lz_encoder #(
    .NUM_NIBBLES(NUM_NIBBLES)
  ) u_lz_encoder (
    .word_i (bus.word_in),
    .idx_o  (lz_idx)
  );

  assign start_idx = (SUPPRESS_LZ != 0) ? lz_idx : 3'(NUM_NIBBLES - 1);

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          snap_d  = bus.word_in;
          idx_d   = start_idx;
          timer_d = '0;
          state_d = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (timer_q == DWELL_LAST) begin
          timer_d = '0;
          if (idx_q == 3'd0) begin
            state_d = ST_FRAME_GAP;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = ST_GAP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_SHOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_FRAME_GAP: begin
        if (timer_q == FGAP_LAST) begin
          timer_d      = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Dropping enable abandons the frame from any state, without a completion pulse.
    if (!bus.enable) begin
      state_d      = ST_IDLE;
      timer_d      = '0;
      frame_done_d = 1'b0;
    end
  end

  always_comb begin
    nib_sel = 4'h0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (idx_d == 3'(i)) nib_sel = snap_d[4*i +: 4];
    end
  end

  // Outputs follow the next state so the first digit appears right after the latch edge.
  assign show_d       = (state_d == ST_SHOW);
  assign nibble_out_d = show_d ? nib_sel : nibble_out_q;
  assign digit_idx_d  = show_d ? idx_d : digit_idx_q;
  assign blank_d      = !show_d;
  assign dp_d         = show_d && (idx_d == 3'd0);

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      snap_q       <= '0;
      idx_q        <= 3'd0;
      nibble_out_q <= 4'h0;
      blank_q      <= 1'b1;
      dp_q         <= 1'b0;
      digit_idx_q  <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      nibble_out_q <= nibble_out_d;
      blank_q      <= blank_d;
      dp_q         <= dp_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.nibble_out = nibble_out_q;
  assign bus.blank      = blank_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = digit_idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_nibble_scanner.sv
// Self-checking bench: two scanners (LZ suppression on/off) against a frame-schedule model.
module tb_display_nibble_scanner;

  localparam int N     = 8;
  localparam int DWELL = 4;
  localparam int GAP   = 2;
  localparam int FG    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] word;

  always #5 clk = ~clk;

  display_nibble_scanner_if #(.NUM_NIBBLES(N)) bus_lz ();
  display_nibble_scanner_if #(.NUM_NIBBLES(N)) bus_nz ();

  assign bus_lz.enable  = enable;
  assign bus_lz.word_in = word;
  assign bus_nz.enable  = enable;
  assign bus_nz.word_in = word;

  display_nibble_scanner #(
    .NUM_NIBBLES(N), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP),
    .FRAME_GAP_CYCLES(FG), .SUPPRESS_LZ(1)
  ) dut_lz (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lz)
  );

  display_nibble_scanner #(
    .NUM_NIBBLES(N), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP),
    .FRAME_GAP_CYCLES(FG), .SUPPRESS_LZ(0)
  ) dut_nz (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nz)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       dp;
    logic [2:0] idx;
    logic       fd;
  } out_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t get_out(input bit lz);
    if (lz) return {bus_lz.nibble_out, bus_lz.blank, bus_lz.dp, bus_lz.digit_idx, bus_lz.frame_done};
    return {bus_nz.nibble_out, bus_nz.blank, bus_nz.dp, bus_nz.digit_idx, bus_nz.frame_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a whole frame is written out as a list of per-cycle outputs
  // when the word is latched, then replayed one entry per clock.
  out_t frame [2][64];
  int   flen  [2];
  int   fpos  [2];
  out_t held  [2];
  out_t expv  [2];

  function automatic void build_frame(input int c, input bit lz, input logic [31:0] w);
    logic [3:0] d [8];
    int start, n;
    for (int k = 0; k < 8; k++) d[k] = w[4*k +: 4];
    start = lz ? 0 : N - 1;
    if (lz) for (int k = 0; k < N; k++) if (d[k] != 4'h0) start = k;
    n = 0;
    for (int k = start; k >= 0; k--) begin
      for (int t = 0; t < DWELL; t++) begin
        frame[c][n] = '{nib: d[k], blank: 1'b0, dp: (k == 0), idx: 3'(k), fd: 1'b0};
        n++;
      end
      if (k > 0) begin
        for (int t = 0; t < GAP; t++) begin
          frame[c][n] = '{nib: d[k], blank: 1'b1, dp: 1'b0, idx: 3'(k), fd: 1'b0};
          n++;
        end
      end
    end
    for (int t = 0; t < FG; t++) begin
      frame[c][n] = '{nib: d[0], blank: 1'b1, dp: 1'b0, idx: 3'd0, fd: 1'b0};
      n++;
    end
    frame[c][n] = '{nib: d[0], blank: 1'b1, dp: 1'b0, idx: 3'd0, fd: 1'b1};
    n++;
    flen[c] = n;
    fpos[c] = 0;
  endfunction

  task automatic model_edge(input int c, input bit lz);
    if (reset) begin
      flen[c] = 0;
      fpos[c] = 0;
      held[c] = '{nib: 4'h0, blank: 1'b1, dp: 1'b0, idx: 3'd0, fd: 1'b0};
    end else if (!enable) begin
      flen[c] = 0;
      fpos[c] = 0;
      held[c] = '{nib: held[c].nib, blank: 1'b1, dp: 1'b0, idx: held[c].idx, fd: 1'b0};
    end else begin
      if (fpos[c] >= flen[c]) build_frame(c, lz, word);
      held[c] = frame[c][fpos[c]];
      fpos[c]++;
    end
    expv[c] = held[c];
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge(0, 1'b1);
      model_edge(1, 1'b0);
      #1;
      check("model_lz", 32'(get_out(1'b1)), 32'(expv[0]));
      check("model_nz", 32'(get_out(1'b0)), 32'(expv[1]));
    end
  end

  typedef struct {
    logic [31:0] word;
    bit          lz;
    logic [3:0]  first_nib;
    logic [2:0]  first_idx;
    int          period;
  } vec_t;

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    for (int k = 0; k < 8; k++) if ($urandom_range(0, 2) == 0) w[4*k +: 4] = 4'h0;
    w = w >> (4 * $urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) w = 32'h0;
    return w;
  endfunction

  initial begin
    vec_t       vecs [8];
    out_t       o;
    int         cnt;
    bit         found;
    int         frames;
    bit         prev_blank;
    logic [3:0] seen [$];
    logic [3:0] exp_seq [4];

    vecs[0] = '{word: 32'h0000_00A5, lz: 1'b1, first_nib: 4'hA, first_idx: 3'd1, period: 14};
    vecs[1] = '{word: 32'h0000_0000, lz: 1'b1, first_nib: 4'h0, first_idx: 3'd0, period: 8};
    vecs[2] = '{word: 32'hDEAD_BEEF, lz: 1'b0, first_nib: 4'hD, first_idx: 3'd7, period: 50};
    vecs[3] = '{word: 32'hDEAD_BEEF, lz: 1'b1, first_nib: 4'hD, first_idx: 3'd7, period: 50};
    vecs[4] = '{word: 32'h0000_00A5, lz: 1'b0, first_nib: 4'h0, first_idx: 3'd7, period: 50};
    vecs[5] = '{word: 32'h00F0_0000, lz: 1'b1, first_nib: 4'hF, first_idx: 3'd5, period: 38};
    vecs[6] = '{word: 32'h8000_0000, lz: 1'b1, first_nib: 4'h8, first_idx: 3'd7, period: 50};
    vecs[7] = '{word: 32'h0000_0001, lz: 1'b1, first_nib: 4'h1, first_idx: 3'd0, period: 8};
    exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4};

    reset  = 1'b1;
    enable = 1'b1;
    word   = 32'h0000_00A5;
    for (int i = 0; i < 2; i++) begin
      tick();
      o = get_out(1'b1);
      check("rst_blank", 32'(o.blank), 32'd1);
      check("rst_dp",    32'(o.dp),    32'd0);
      check("rst_nib",   32'(o.nib),   32'd0);
      check("rst_idx",   32'(o.idx),   32'd0);
      check("rst_fd",    32'(o.fd),    32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      enable = 1'b0;
      tick();
      tick();
      word   = vecs[i].word;
      enable = 1'b1;
      tick();
      o = get_out(vecs[i].lz);
      check($sformatf("vec%0d_first_blank", i), 32'(o.blank), 32'd0);
      check($sformatf("vec%0d_first_nib", i),   32'(o.nib),   32'(vecs[i].first_nib));
      check($sformatf("vec%0d_first_idx", i),   32'(o.idx),   32'(vecs[i].first_idx));
      found = 1'b0;
      cnt   = 0;
      while (!found && cnt < 200) begin
        tick();
        cnt++;
        if (get_out(vecs[i].lz).fd) found = 1'b1;
      end
      check($sformatf("vec%0d_fd_seen", i), 32'(found), 32'd1);
      found = 1'b0;
      cnt   = 0;
      while (!found && cnt < 200) begin
        tick();
        cnt++;
        if (get_out(vecs[i].lz).fd) found = 1'b1;
      end
      check($sformatf("vec%0d_period", i), 32'(cnt), 32'(vecs[i].period));
    end

    // Word changes during the first digit must only appear in the following frame.
    enable = 1'b0;
    tick();
    tick();
    word   = 32'h12;
    enable = 1'b1;
    tick();
    o = get_out(1'b1);
    seen.push_back(o.nib);
    prev_blank = o.blank;
    tick();
    word   = 32'h34;
    frames = 0;
    cnt    = 0;
    while (frames < 2 && cnt < 100) begin
      tick();
      cnt++;
      o = get_out(1'b1);
      if (!o.blank && prev_blank) seen.push_back(o.nib);
      prev_blank = o.blank;
      if (o.fd) frames++;
    end
    check("tear_frames", 32'(frames), 32'd2);
    check("tear_count",  32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check($sformatf("tear_digit%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

    // Enable drop on the second SHOW cycle, then restart from the top digit.
    enable = 1'b0;
    tick();
    tick();
    word   = 32'h0000_00A5;
    enable = 1'b1;
    tick();
    tick();
    check("drop_show2_blank", 32'(get_out(1'b1).blank), 32'd0);
    enable = 1'b0;
    tick();
    o = get_out(1'b1);
    check("drop_blank", 32'(o.blank), 32'd1);
    check("drop_dp",    32'(o.dp),    32'd0);
    check("drop_nib",   32'(o.nib),   32'hA);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (get_out(1'b1).fd || get_out(1'b0).fd) found = 1'b1;
    end
    check("drop_no_fd", 32'(found), 32'd0);
    enable = 1'b1;
    tick();
    o = get_out(1'b1);
    check("reen_lz_nib",   32'(o.nib),   32'hA);
    check("reen_lz_idx",   32'(o.idx),   32'd1);
    check("reen_lz_blank", 32'(o.blank), 32'd0);
    o = get_out(1'b0);
    check("reen_nz_nib",   32'(o.nib),   32'h0);
    check("reen_nz_idx",   32'(o.idx),   32'd7);

    // Random word changes, enable toggles and occasional resets, checked by the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 19) == 0) word = rand_word();
      if (enable) begin
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 4) == 0) enable = 1'b1;
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
